// File: rtl/reg_dump_ctrl.sv
// Debug register dump sequencer: walks the register file through the decode
// stage debug read port and streams each word LSB-first to the UART TX.
module reg_dump_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_data_reg_debug_unit,
    input  logic               i_tx_done,
    output logic               o_ctrl_read_debug_reg,
    output logic [NB_REG-1:0]  o_addr_debug_unit,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(N_BYTES - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        LATCH    = 3'd2,
        SEND     = 3'd3,
        WAIT_TX  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [NB_REG-1:0]  reg_cnt, reg_cnt_next;
    logic [NB_BCNT-1:0] byte_cnt, byte_cnt_next;
    logic [NB_DATA-1:0] shift, shift_next;

    // State, counters and word shift register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            reg_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            reg_cnt  <= reg_cnt_next;
            byte_cnt <= byte_cnt_next;
            shift    <= shift_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_next    = state;
        reg_cnt_next  = reg_cnt;
        byte_cnt_next = byte_cnt;
        shift_next    = shift;
        case (state)
            IDLE: begin
                reg_cnt_next  = '0;
                byte_cnt_next = '0;
                if (i_start) state_next = SET_ADDR;
            end
            SET_ADDR: state_next = LATCH;
            LATCH: begin
                shift_next    = i_data_reg_debug_unit;
                byte_cnt_next = '0;
                state_next    = SEND;
            end
            SEND: state_next = WAIT_TX;
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (byte_cnt < LAST_BYTE) begin
                        shift_next    = shift >> NB_BYTE;
                        byte_cnt_next = byte_cnt + NB_BCNT'(1);
                        state_next    = SEND;
                    end else if (reg_cnt < LAST_REG) begin
                        reg_cnt_next = reg_cnt + NB_REG'(1);
                        state_next   = SET_ADDR;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                reg_cnt_next  = '0;
                byte_cnt_next = '0;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_abort) begin
            state_next    = IDLE;
            reg_cnt_next  = '0;
            byte_cnt_next = '0;
        end
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_ctrl_read_debug_reg <= 1'b0;
            o_tx_start            <= 1'b0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
        end else begin
            o_ctrl_read_debug_reg <= state_next inside {SET_ADDR, LATCH, SEND, WAIT_TX};
            o_tx_start            <= (state_next == SEND);
            o_busy                <= (state_next != IDLE);
            o_done                <= (state_next == DONE);
        end
    end

    assign o_addr_debug_unit = reg_cnt;
    assign o_tx_data         = shift[NB_BYTE-1:0];

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a register-file model and an
// auto-acking UART TX responder.
module tb_reg_dump_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_abort;
    logic [31:0] i_data_reg_debug_unit;
    logic        i_tx_done;
    logic        o_ctrl_read_debug_reg;
    logic [4:0]  o_addr_debug_unit;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;

    logic [31:0] regs [32];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  byte_q[$];
    logic [4:0]  addr_q[$];
    int          done_cnt = 0;

    int          ack_dly = 2;
    bit          tx_auto = 1'b0;
    int          ack_cnt = 0;

    reg_dump_ctrl dut (
        .i_clock               (i_clock),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .i_abort               (i_abort),
        .i_data_reg_debug_unit (i_data_reg_debug_unit),
        .i_tx_done             (i_tx_done),
        .o_ctrl_read_debug_reg (o_ctrl_read_debug_reg),
        .o_addr_debug_unit     (o_addr_debug_unit),
        .o_tx_data             (o_tx_data),
        .o_tx_start            (o_tx_start),
        .o_busy                (o_busy),
        .o_done                (o_done)
    );

    always #5 i_clock = ~i_clock;

    assign i_data_reg_debug_unit = regs[o_addr_debug_unit];

    // UART TX model: pulses i_tx_done ack_dly cycles after each strobe
    always @(negedge i_clock) begin
        i_tx_done = 1'b0;
        if (!i_reset || !tx_auto) ack_cnt = 0;
        else if (o_tx_start) ack_cnt = ack_dly;
        else if (ack_cnt > 0) begin
            ack_cnt = ack_cnt - 1;
            if (ack_cnt == 0) i_tx_done = 1'b1;
        end
    end

    always @(negedge i_clock) begin
        if (o_tx_start) begin
            byte_q.push_back(o_tx_data);
            addr_q.push_back(o_addr_debug_unit);
        end
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge i_clock);
        #1;
    endtask

    // Full dump with ack 2 cycles after each strobe; optionally re-request during reg 7
    task automatic run_dump(input bit inject);
        int steps;
        int base;
        int dbase;
        int bad;
        bit injected;
        logic [31:0] w;
        base  = byte_q.size();
        dbase = done_cnt;
        ack_dly = 2;
        tx_auto = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        steps = 0;
        injected = 1'b0;
        while (done_cnt == dbase && steps < 5000) begin
            if (inject && !injected && o_addr_debug_unit == 5'd7 && byte_q.size() - base == 29) begin
                i_start = 1'b1;
                step();
                i_start = 1'b0;
                injected = 1'b1;
            end else begin
                step();
            end
            steps++;
        end
        check("dump_timeout", 32'(steps < 5000), 32'd1);
        check("done_pulse", 32'(o_done), 32'd1);
        check("ctrl_at_done", 32'(o_ctrl_read_debug_reg), 32'd0);
        step();
        check("busy_after_done", {o_busy, o_ctrl_read_debug_reg, o_done}, 32'd0);
        repeat (4) step();
        check("done_count", done_cnt - dbase, 32'd1);
        check("strobe_count", byte_q.size() - base, 32'd128);
        check("reg1_b0", 32'(byte_q[base+4]), 32'h01);
        check("reg1_b1", 32'(byte_q[base+5]), 32'hC0);
        check("reg1_b2", 32'(byte_q[base+6]), 32'hB0);
        check("reg1_b3", 32'(byte_q[base+7]), 32'hA0);
        bad = 0;
        for (int k = 0; k < 128; k++) begin
            w = (32'hA0B0C000 + 32'(k / 4)) >> (8 * (k % 4));
            if (byte_q[base+k] !== w[7:0]) bad++;
            if (addr_q[base+k] !== 5'(k / 4)) bad++;
        end
        check("stream_errors", bad, 32'd0);
    endtask

    initial begin
        int steps;
        int base;
        int dbase;
        bit bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA0B0C000 + 32'(i);

        // Reset with random inputs
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_start = 1'($urandom);
            i_abort = 1'($urandom);
            step();
            check("reset_outputs", {o_ctrl_read_debug_reg, o_addr_debug_unit, o_tx_data,
                                    o_tx_start, o_busy, o_done}, 32'd0);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        step();
        i_reset = 1'b1;
        repeat (5) step();
        check("idle_no_activity", {o_busy, o_ctrl_read_debug_reg}, 32'd0);
        check("idle_no_strobes", byte_q.size(), 32'd0);

        // Start and abort together in IDLE
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        step();
        check("start_abort_idle", {o_busy, o_ctrl_read_debug_reg, o_tx_start}, 32'd0);

        // Slow TX: first strobe latency and hold during a 20-cycle wait
        dbase = done_cnt;
        ack_dly = 20;
        tx_auto = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("cycle1_set_addr", {o_busy, o_ctrl_read_debug_reg, o_tx_start, 3'(o_addr_debug_unit)}, 32'b110000);
        step();
        check("cycle2_no_strobe", 32'(o_tx_start), 32'd0);
        step();
        check("cycle3_strobe", {o_tx_start, o_tx_data}, {1'b1, 8'h00});
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b1) bad = 1'b1;
        end
        check("slow_tx_hold", 32'(bad), 32'd0);
        step();
        check("slow_tx_next", {o_tx_start, o_tx_data}, {1'b1, 8'hC0});
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_in_send", {o_busy, o_tx_start, o_ctrl_read_debug_reg}, 32'd0);
        check("abort_no_done", done_cnt - dbase, 32'd0);

        // Full dump with i_start asserted during reg 7
        run_dump(1'b1);

        // Abort in WAIT_TX of reg 5 byte 2
        base  = byte_q.size();
        dbase = done_cnt;
        ack_dly = 2;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        steps = 0;
        while (!(byte_q.size() - base == 23 && o_tx_start) && steps < 2000) begin
            step();
            steps++;
        end
        check("abort_reach_timeout", 32'(steps < 2000), 32'd1);
        check("abort_point_byte", {3'(o_addr_debug_unit), o_tx_data}, {3'd5, 8'hB0});
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_wait_idle", {o_busy, o_tx_start, o_ctrl_read_debug_reg, o_done}, 32'd0);
        repeat (4) step();
        check("abort_no_done2", done_cnt - dbase, 32'd0);
        check("abort_no_more_strobes", byte_q.size() - base, 32'd23);

        // Restart after abort begins at register 0 byte 0
        base = byte_q.size();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        check("restart_first", {o_tx_start, 3'(o_addr_debug_unit), o_tx_data}, {1'b1, 3'd0, 8'h00});

        // Asynchronous reset in WAIT_TX, off the clock edge
        steps = 0;
        while (!(byte_q.size() - base == 10 && o_tx_start) && steps < 2000) begin
            step();
            steps++;
        end
        step();
        check("pre_reset_wait", {o_busy, o_tx_start}, 32'b10);
        #2;
        i_reset = 1'b0;
        #1;
        check("async_reset_outputs", {o_ctrl_read_debug_reg, o_addr_debug_unit, o_tx_data,
                                      o_tx_start, o_busy, o_done}, 32'd0);
        step();
        i_reset = 1'b1;
        step();

        run_dump(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
